// File: rtl/rf_write_arbiter.sv
// Purpose : three-requester write arbiter in front of a 2**D x W register file,
//           with a zero-fill sweep of every entry started by clear_start.
// Latency : one cycle from transfer (valid & ready) to the registered rf_* write.
//           Backpressure: req_ready is combinational; only one requester is accepted
//           per cycle, and none while clear_start is high, during the sweep or in reset.
//
// Ports:
//   CLK, reset_n             - clock; asynchronous active-low reset
//   req_valid/waddr/data     - per-requester request, slice i belongs to requester i
//   req_ready                - one-hot (or zero) accept, combinational
//   clear_start              - single-cycle pulse starting the zero-fill sweep
//   busy                     - high while the sweep runs
//   grant_id                 - last accepted requester; 3 marks a sweep write
//   rf_write_en/waddr/data_in - registered write port to the register file
//
// Build option: define RF_ARB_FIXED_PRIO_EN for fixed priority (0 > 1 > 2) instead
// of round-robin; the rotating priority pointer is then removed.
module rf_write_arbiter #(
    parameter int W = 8,
    parameter int D = 2
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic [2:0]       req_valid,
    input  logic [3*D-1:0]   req_waddr,
    input  logic [3*W-1:0]   req_data,
    output logic [2:0]       req_ready,
    input  logic             clear_start,
    output logic             busy,
    output logic [1:0]       grant_id,
    output logic             rf_write_en,
    output logic [D-1:0]     rf_waddr,
    output logic [W-1:0]     rf_data_in
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [D-1:0] CNT_LAST = {D{1'b1}};

    state_t      state;
    state_t      state_nxt;
    logic [D-1:0] cnt;

    // Requester indices in descending priority for this cycle.
    logic [1:0]  order [3];
    logic        gnt_hit;
    logic [1:0]  gnt_idx;
    logic        accept;
    logic        xfer;

`ifdef RF_ARB_FIXED_PRIO_EN
    always_comb begin
        order[0] = 2'd0;
        order[1] = 2'd1;
        order[2] = 2'd2;
    end
`else
    logic [1:0]  ptr;

    // Rotate the priority order so that requester ptr is checked first.
    always_comb begin
        order[0] = ptr;
        order[1] = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        order[2] = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 2'd0;
        end else if (xfer) begin
            ptr <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
        end
    end
`endif

    // First valid requester in priority order.
    always_comb begin
        gnt_hit = 1'b0;
        gnt_idx = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_hit && req_valid[order[k]]) begin
                gnt_hit = 1'b1;
                gnt_idx = order[k];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. clear_start inside CLEAR is deliberately ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB:     if (clear_start)      state_nxt = CLEAR;
            CLEAR:   if (cnt == CNT_LAST)  state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    // FSM: outputs. A clear request wins over any pending write request.
    always_comb begin
        accept    = reset_n && (state == ARB) && !clear_start;
        req_ready = (accept && gnt_hit) ? (3'b001 << gnt_idx) : 3'b000;
        busy      = (state == CLEAR);
    end

    assign xfer = |req_ready;

    // Sweep counter: zeroed on entry, wraps back to 0 on the last sweep write.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (state == ARB && clear_start) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered write port; address, data and id hold when nothing is written.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_en <= 1'b0;
            rf_waddr    <= '0;
            rf_data_in  <= '0;
            grant_id    <= 2'd0;
        end else begin
            rf_write_en <= xfer || (state == CLEAR);
            if (state == CLEAR) begin
                rf_waddr   <= cnt;
                rf_data_in <= '0;
                grant_id   <= 2'd3;
            end else if (xfer) begin
                rf_waddr   <= req_waddr[int'(gnt_idx)*D +: D];
                rf_data_in <= req_data[int'(gnt_idx)*W +: W];
                grant_id   <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Purpose : directed self-checking bench for rf_write_arbiter (W=8, D=2).
// Latency : checks the one-cycle request-to-write path and the 4-cycle sweep.
// Backpressure: checks req_ready gating by clear_start, sweep and reset.
module tb_rf_write_arbiter;

    localparam int W = 8;
    localparam int D = 2;

    logic             CLK = 1'b0;
    logic             reset_n;
    logic [2:0]       req_valid;
    logic [3*D-1:0]   req_waddr;
    logic [3*W-1:0]   req_data;
    logic [2:0]       req_ready;
    logic             clear_start;
    logic             busy;
    logic [1:0]       grant_id;
    logic             rf_write_en;
    logic [D-1:0]     rf_waddr;
    logic [W-1:0]     rf_data_in;

    int n_tests = 0;
    int n_fail  = 0;

    rf_write_arbiter #(.W(W), .D(D)) dut (
        .CLK         (CLK),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_waddr   (req_waddr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .clear_start (clear_start),
        .busy        (busy),
        .grant_id    (grant_id),
        .rf_write_en (rf_write_en),
        .rf_waddr    (rf_waddr),
        .rf_data_in  (rf_data_in)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_wr(input string tag, input logic en, input int addr,
                            input int data, input int gid);
        check({tag, "_we"},   32'(rf_write_en), 32'(en));
        check({tag, "_addr"}, 32'(rf_waddr),    32'(addr));
        check({tag, "_data"}, 32'(rf_data_in),  32'(data));
        check({tag, "_gid"},  32'(grant_id),    32'(gid));
    endtask

    // Reset pulse spanning one rising edge; returns at a falling edge.
    task automatic do_reset();
        @(negedge CLK);
        reset_n     = 1'b0;
        req_valid   = 3'b000;
        clear_start = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_gnt [4];
        reset_n     = 1'b0;
        req_valid   = 3'b111;
        req_waddr   = '0;
        req_data    = '0;
        clear_start = 1'b0;

        // Reset state; req_ready must stay low in reset even with requests.
        #12;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check_wr("rst", 1'b0, 0, 0, 0);
        @(negedge CLK);
        req_valid = 3'b000;
        reset_n   = 1'b1;

        // Single request from requester 1.
        @(negedge CLK);
        req_valid = 3'b010;
        req_waddr[1*D +: D] = 2'd2;
        req_data[1*W +: W]  = 8'hA5;
        #1 check("single_ready", 32'(req_ready), 32'b010);
        @(negedge CLK);
        req_valid = 3'b000;
        check_wr("single", 1'b1, 2, 8'hA5, 1);
        @(negedge CLK);
        check_wr("idle_hold", 1'b0, 2, 8'hA5, 1);

        // All three valid continuously from reset.
`ifdef RF_ARB_FIXED_PRIO_EN
        exp_gnt = '{0, 0, 0, 0};
`else
        exp_gnt = '{0, 1, 2, 0};
`endif
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_waddr[i*D +: D] = D'(i);
            req_data[i*W +: W]  = W'(8'h10 + i);
        end
        req_valid = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(3'b001 << exp_gnt[k]));
            @(negedge CLK);
            check_wr($sformatf("rr_wr%0d", k), 1'b1, exp_gnt[k], 8'h10 + exp_gnt[k], exp_gnt[k]);
        end
        req_valid = 3'b000;

        // Sweep with requester 0 pending, plus a duplicate clear_start mid-sweep.
        do_reset();
        req_valid = 3'b001;
        req_waddr[0*D +: D] = 2'd1;
        req_data[0*W +: W]  = 8'h77;
        clear_start = 1'b1;
        #1 check("clr_entry_ready", 32'(req_ready), 32'd0);
        check("clr_entry_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        clear_start = 1'b0;
        check("clr_busy0", 32'(busy), 32'd1);
        check("clr_nowr", 32'(rf_write_en), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            clear_start = (k == 1);
            check_wr($sformatf("sweep%0d", k), 1'b1, k, 0, 3);
            check($sformatf("sweep_busy%0d", k), 32'(busy), 32'(k < 3));
            #1 check($sformatf("sweep_ready%0d", k), 32'(req_ready),
                     (k < 3) ? 32'd0 : 32'b001);
        end
        @(negedge CLK);
        req_valid = 3'b000;
        check_wr("post_sweep", 1'b1, 1, 8'h77, 0);
        check("post_sweep_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        check("post_sweep_idle", 32'(rf_write_en), 32'd0);

        // Reset after two sweep writes aborts the sweep.
        do_reset();
        clear_start = 1'b1;
        @(negedge CLK);
        clear_start = 1'b0;
        @(negedge CLK);
        check_wr("abort_w0", 1'b1, 0, 0, 3);
        @(negedge CLK);
        check_wr("abort_w1", 1'b1, 1, 0, 3);
        reset_n = 1'b0;
        #1 check_wr("abort_rst", 1'b0, 0, 0, 0);
        check("abort_rst_busy", 32'(busy), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check($sformatf("abort_we%0d", k),   32'(rf_write_en), 32'd0);
            check($sformatf("abort_busy%0d", k), 32'(busy),        32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
